// File: rtl/fetch_arbiter_if.sv
// Fetch-port bundle: per-core PC requests and responses plus the shared program-memory read channel.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface fetch_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_pc;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [INST_WIDTH-1:0]         rsp_instruction;
  logic                          mem_read_valid;
  logic [ADDR_WIDTH-1:0]         mem_read_addr;
  logic                          mem_read_ready;
  logic                          mem_read_data_valid;
  logic [INST_WIDTH-1:0]         mem_read_data;
  logic                          busy;

  modport slave (
    input  req_valid, req_pc, mem_read_ready, mem_read_data_valid, mem_read_data,
    output rsp_valid, rsp_instruction, mem_read_valid, mem_read_addr, busy
  );

  modport master (
    output req_valid, req_pc, mem_read_ready, mem_read_data_valid, mem_read_data,
    input  rsp_valid, rsp_instruction, mem_read_valid, mem_read_addr, busy
  );
endinterface

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter sharing one program-memory read port among NUM_REQ fetchers; 3-cycle minimum
// request-to-response latency, one fetch per 4 cycles; memory stalls simply hold the current state.
module fetch_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int INST_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  fetch_arbiter_if.slave   bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT, RESPOND} state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      grant_idx_q, grant_idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [INST_WIDTH-1:0] data_q, data_d;

  logic                  win_vld;
  logic [PTR_W-1:0]      win_idx;
  logic [PTR_W-1:0]      cand;
  logic [ADDR_WIDTH-1:0] win_pc;

  // Scan starts at rr_ptr and wraps; the first requester found in that order wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_vld && bus.req_valid[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    win_pc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) win_pc = bus.req_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    addr_d      = addr_q;
    data_d      = data_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d     = REQUEST;
          grant_idx_d = win_idx;
          addr_d      = win_pc;
          rr_ptr_d    = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);
        end
      end
      REQUEST: if (bus.mem_read_ready) state_d = WAIT;
      // Data strobes outside WAIT never reach data_q.
      WAIT: begin
        if (bus.mem_read_data_valid) begin
          data_d  = bus.mem_read_data;
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    bus.mem_read_valid  = (state_q == REQUEST);
    bus.mem_read_addr   = addr_q;
    bus.busy            = (state_q != IDLE);
    bus.rsp_valid       = '0;
    bus.rsp_instruction = '0;
    if (state_q == RESPOND) begin
      bus.rsp_valid[grant_idx_q] = 1'b1;
      bus.rsp_instruction        = data_q;
    end
  end
endmodule

// File: tb/tb_fetch_arbiter.sv
// Bench for fetch_arbiter: requester and memory models drive the bus, a scoreboard of expected
// addresses and responses is filled as requests are raised and drained as the DUT answers.
module tb_fetch_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int IW = 32;

  typedef struct {
    int          idx;
    logic [31:0] data;
    bit          lat_chk;
  } exp_t;

  logic clk;
  logic reset;
  fetch_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

  fetch_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int got[NR];
  int target[NR];
  int start_cyc[NR];
  int rdy_stall = 0;
  int data_stall = 0;
  bit spurious = 0;
  bit mem_idle = 1;
  logic [AW-1:0] exp_addr_q[$];
  exp_t          exp_rsp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {8'hC0, a, ~a, 8'h5A};
  endfunction

  task automatic set_pc(input int i, input logic [AW-1:0] pc);
    bus.req_pc[i*AW +: AW] = pc;
  endtask

  task automatic push_exp(input int i, input logic [AW-1:0] pc, input bit lat);
    exp_t e;
    e.idx     = i;
    e.data    = mem_word(pc);
    e.lat_chk = lat;
    exp_addr_q.push_back(pc);
    exp_rsp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((exp_rsp_q.size() != 0 || exp_addr_q.size() != 0 || !mem_idle || bus.busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_in_budget", 64'(n < budget), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Requesters hold req_valid until they have collected target[i] responses.
  initial begin
    logic [NR-1:0] seen;
    bus.req_valid = '0;
    for (int i = 0; i < NR; i++) begin
      got[i] = 0;
      target[i] = 0;
      start_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      seen = bus.rsp_valid;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (seen[i]) got[i]++;
        if ((got[i] < target[i]) && !bus.req_valid[i]) start_cyc[i] = cyc;
        bus.req_valid[i] = (got[i] < target[i]);
      end
    end
  end

  // Memory model: optional ready stall, optional spurious strobes during REQUEST, then data after data_stall.
  initial begin
    logic [AW-1:0] a0;
    logic [AW-1:0] ea;
    bus.mem_read_ready      = 1'b0;
    bus.mem_read_data_valid = 1'b0;
    bus.mem_read_data       = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_read_valid && !reset) begin
        mem_idle = 0;
        a0 = bus.mem_read_addr;
        if (exp_addr_q.size() == 0) begin
          check_eq("mem_unexpected_req", 64'(a0), 64'hFFFF);
        end else begin
          ea = exp_addr_q.pop_front();
          check_eq("mem_addr", 64'(a0), 64'(ea));
        end
        for (int n = 0; n < rdy_stall; n++) begin
          bus.mem_read_ready      = 1'b0;
          bus.mem_read_data_valid = spurious;
          bus.mem_read_data       = 32'hBAD0BAD0;
          @(negedge clk);
          check_eq("stall_valid_hold", 64'(bus.mem_read_valid), 64'd1);
          check_eq("stall_addr_hold", 64'(bus.mem_read_addr), 64'(a0));
        end
        bus.mem_read_ready      = 1'b1;
        bus.mem_read_data_valid = spurious;
        bus.mem_read_data       = 32'hBAD0BAD0;
        @(negedge clk);
        bus.mem_read_ready      = 1'b0;
        bus.mem_read_data_valid = 1'b0;
        bus.mem_read_data       = '0;
        repeat (data_stall) @(negedge clk);
        bus.mem_read_data_valid = 1'b1;
        bus.mem_read_data       = mem_word(a0);
        @(negedge clk);
        bus.mem_read_data_valid = 1'b0;
        bus.mem_read_data       = '0;
        mem_idle = 1;
      end
    end
  end

  // Response monitor: every pulse must match the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset && bus.rsp_valid != '0) begin
      if (exp_rsp_q.size() == 0) begin
        check_eq("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      end else begin
        e = exp_rsp_q.pop_front();
        check_eq("rsp_onehot", 64'(bus.rsp_valid), 64'(1) << e.idx);
        check_eq("rsp_data", 64'(bus.rsp_instruction), 64'(e.data));
        if (e.lat_chk) check_eq("rsp_latency", 64'(cyc - start_cyc[e.idx]), 64'd3);
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.req_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rst_rsp_inst", 64'(bus.rsp_instruction), 64'd0);
    check_eq("rst_mem_valid", 64'(bus.mem_read_valid), 64'd0);
    check_eq("rst_mem_addr", 64'(bus.mem_read_addr), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    reset = 1'b0;

    // Single request from core 2, minimum latency
    @(negedge clk);
    set_pc(2, 8'h10);
    push_exp(2, 8'h10, 1'b1);
    target[2] = got[2] + 1;
    wait_done(100);

    // rr_ptr is now 3: cores 0 and 3 together must grant 3 first
    set_pc(0, 8'h60);
    set_pc(3, 8'h6C);
    push_exp(3, 8'h6C, 1'b0);
    push_exp(0, 8'h60, 1'b0);
    target[0] = got[0] + 1;
    target[3] = got[3] + 1;
    wait_done(100);

    // Reset while waiting for data (rr_ptr becomes 2 before reset)
    set_pc(1, 8'h44);
    exp_addr_q.push_back(8'h44);
    data_stall = 4;
    target[1] = got[1] + 1;
    n = 0;
    while (!(bus.busy && !bus.mem_read_valid && exp_addr_q.size() == 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("reached_wait", 64'(n < 50), 64'd1);
    target[1] = got[1];
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2;
    check_eq("rstw_busy", 64'(bus.busy), 64'd0);
    check_eq("rstw_mem_valid", 64'(bus.mem_read_valid), 64'd0);
    check_eq("rstw_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_eq("rstw_mem_addr", 64'(bus.mem_read_addr), 64'd0);
    reset = 1'b0;
    n = 0;
    while (!mem_idle && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check_eq("late_data_ignored_busy", 64'(bus.busy), 64'd0);
    data_stall = 1;

    // All four valid after reset: order restarts at 0
    for (int i = 0; i < NR; i++) begin
      set_pc(i, 8'(i * 4));
      push_exp(i, 8'(i * 4), 1'b0);
      target[i] = got[i] + 1;
    end
    wait_done(200);
    data_stall = 0;

    // Ready stall with spurious data strobes during REQUEST
    rdy_stall = 5;
    spurious = 1'b1;
    set_pc(0, 8'h20);
    push_exp(0, 8'h20, 1'b0);
    target[0] = got[0] + 1;
    wait_done(100);
    rdy_stall = 0;
    spurious = 1'b0;

    // Granted core 1 changes its PC and drops valid mid-transaction
    set_pc(1, 8'h30);
    push_exp(1, 8'h30, 1'b0);
    target[1] = got[1] + 1;
    n = 0;
    while (!bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("grant_seen", 64'(n < 50), 64'd1);
    set_pc(1, 8'h99);
    target[1] = got[1];
    wait_done(100);

    // rr_ptr is 2: cores 1 and 3 continuously valid alternate 3,1,3,1
    set_pc(1, 8'h50);
    set_pc(3, 8'h70);
    push_exp(3, 8'h70, 1'b0);
    push_exp(1, 8'h50, 1'b0);
    push_exp(3, 8'h70, 1'b0);
    push_exp(1, 8'h50, 1'b0);
    target[1] = got[1] + 2;
    target[3] = got[3] + 2;
    wait_done(200);
    check_eq("final_busy", 64'(bus.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
